// File: rtl/lab3_cache_mem_arbiter.sv
// Two-port val/rdy memory arbiter with an in-order owner FIFO for response routing.
// Define LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN for fixed priority (port 1 wins); default is round-robin.

package lab3_cache_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module lab3_cache_mem_arbiter
    import lab3_cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned p_depth = 2
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_val,
    output logic         req0_rdy,
    input  mem_req_4B_t  req0_msg,
    output logic         resp0_val,
    input  logic         resp0_rdy,
    output mem_resp_4B_t resp0_msg,

    input  logic         req1_val,
    output logic         req1_rdy,
    input  mem_req_4B_t  req1_msg,
    output logic         resp1_val,
    input  logic         resp1_rdy,
    output mem_resp_4B_t resp1_msg,

    output logic         mem_req_val,
    input  logic         mem_req_rdy,
    output mem_req_4B_t  mem_req_msg,
    input  logic         mem_resp_val,
    output logic         mem_resp_rdy,
    input  mem_resp_4B_t mem_resp_msg,

    output logic         idle
);

    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CNT_W = $clog2(p_depth + 1);

    logic [p_depth-1:0] r_owner;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [p_depth-1:0] w_owner_nxt;
    logic [PTR_W-1:0]   w_head_nxt;
    logic [PTR_W-1:0]   w_tail_nxt;
    logic [CNT_W-1:0]   w_count_nxt;

    logic w_full;
    logic w_empty;
    logic w_grant;
    logic w_head_owner;
    logic w_req_fire;
    logic w_resp_fire;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full       = (r_count == CNT_W'(p_depth));
    assign w_empty      = (r_count == '0);
    assign w_head_owner = r_owner[r_head];

`ifdef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
    assign w_grant = req1_val;
`else
    logic r_prio;
    logic w_prio_nxt;

    // Favoured port only matters when both ports are requesting.
    assign w_grant = (req0_val & req1_val) ? r_prio : req1_val;
`endif

    // Request side: gated by reset so nothing is offered while held in reset.
    assign mem_req_val = (req0_val | req1_val) & ~w_full & reset;
    assign mem_req_msg = w_grant ? req1_msg : req0_msg;
    assign req0_rdy    = ~w_grant & mem_req_rdy & ~w_full & reset;
    assign req1_rdy    =  w_grant & mem_req_rdy & ~w_full & reset;
    assign w_req_fire  = mem_req_val & mem_req_rdy;

    // Response side: routed to the owner at the FIFO head only.
    assign resp0_val    = mem_resp_val & ~w_empty & ~w_head_owner;
    assign resp1_val    = mem_resp_val & ~w_empty &  w_head_owner;
    assign mem_resp_rdy = (w_head_owner ? resp1_rdy : resp0_rdy) & ~w_empty;
    assign resp0_msg    = mem_resp_msg;
    assign resp1_msg    = mem_resp_msg;
    assign w_resp_fire  = mem_resp_val & mem_resp_rdy;

    assign idle = w_empty;

    always_comb begin
        w_owner_nxt = r_owner;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
`ifndef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
        w_prio_nxt  = r_prio;
`endif
        if (w_req_fire) begin
            w_owner_nxt[r_tail] = w_grant;
            w_tail_nxt          = f_inc(r_tail);
`ifndef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
            w_prio_nxt          = ~w_grant;
`endif
        end
        if (w_resp_fire) begin
            w_head_nxt = f_inc(r_head);
        end
        case ({w_req_fire, w_resp_fire})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
`ifndef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
            r_prio  <= 1'b0;
`endif
        end else begin
            r_owner <= w_owner_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
`ifndef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
            r_prio  <= w_prio_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Directed self-checking bench for lab3_cache_mem_arbiter (p_depth = 2).
module tb_lab3_cache_mem_arbiter;
    import lab3_cache_mem_arbiter_pkg::*;

    logic         clk;
    logic         reset;
    logic         req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic         req1_val, req1_rdy, resp1_val, resp1_rdy;
    logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic         idle;
    mem_req_4B_t  req0_msg, req1_msg, mem_req_msg;
    mem_resp_4B_t resp0_msg, resp1_msg, mem_resp_msg;

    int checks = 0;
    int errors = 0;

`ifdef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    lab3_cache_mem_arbiter #(.p_depth(2)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_req_4B_t mk_req(input logic [7:0] op, input logic [31:0] addr);
        mem_req_4B_t m;
        m.typ = 3'd0; m.opaque = op; m.addr = addr; m.len = 2'd0; m.data = 32'h0;
        return m;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input logic [7:0] op, input logic [31:0] data);
        mem_resp_4B_t m;
        m.typ = 3'd0; m.opaque = op; m.test = 2'd0; m.len = 2'd0; m.data = data;
        return m;
    endfunction

    task automatic clear_inputs();
        req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
        mem_req_rdy = 0; mem_resp_val = 0;
        req0_msg = mk_req(8'h00, 32'h0); req1_msg = mk_req(8'h00, 32'h0);
        mem_resp_msg = mk_resp(8'h00, 32'h0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        repeat (2) tick();
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        req0_val = 1; req0_msg = mk_req(8'h01, 32'h0000_1000);
        mem_req_rdy = 1; mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        repeat (3) begin
            #1;
            checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL rst_mem_req_val got %0b exp 0", mem_req_val); end
            checks++; if ({req0_rdy, req1_rdy} !== 2'b00) begin errors++; $display("FAIL rst_req_rdy got %b exp 00", {req0_rdy, req1_rdy}); end
            checks++; if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b000) begin errors++; $display("FAIL rst_resp got %b exp 000", {resp0_val, resp1_val, mem_resp_rdy}); end
            checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b exp 1", idle); end
            tick();
        end
        mem_resp_val = 0;
        reset = 1;
        #1;
        checks++; if (mem_req_val !== 1'b1 || req0_rdy !== 1'b1) begin errors++; $display("FAIL first_req val/rdy got %0b/%0b exp 1/1", mem_req_val, req0_rdy); end
        checks++; if (mem_req_msg.addr !== 32'h0000_1000) begin errors++; $display("FAIL first_req_addr got %h exp 00001000", mem_req_msg.addr); end
        tick();
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL first_req_idle got %0b exp 0", idle); end
        req0_val = 0;
        mem_resp_val = 1; mem_resp_msg = mk_resp(8'h01, 32'h1234_5678);
        #1;
        checks++; if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b101) begin errors++; $display("FAIL first_resp got %b exp 101", {resp0_val, resp1_val, mem_resp_rdy}); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL first_resp_idle got %0b exp 1", idle); end
    endtask

    task automatic test_round_robin();
        logic g_exp, prev;
        do_reset();
        req0_val = 1; req0_msg = mk_req(8'h10, 32'h0000_0100);
        req1_val = 1; req1_msg = mk_req(8'h21, 32'h0000_0200);
        mem_req_rdy = 1; mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        mem_resp_msg = mk_resp(8'h55, 32'h0000_CAFE);
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g_exp = FIXED ? 1'b1 : i[0];
            #1;
            checks++; if ({req1_rdy, req0_rdy} !== {g_exp, ~g_exp}) begin errors++; $display("FAIL rr_grant cyc %0d got r1/r0=%b exp %b", i, {req1_rdy, req0_rdy}, {g_exp, ~g_exp}); end
            checks++; if (mem_req_msg !== (g_exp ? req1_msg : req0_msg)) begin errors++; $display("FAIL rr_msg cyc %0d got %h exp %h", i, mem_req_msg, (g_exp ? req1_msg : req0_msg)); end
            if (i > 0) begin
                checks++; if ({resp1_val, resp0_val} !== {prev, ~prev}) begin errors++; $display("FAIL rr_route cyc %0d got %b exp %b", i, {resp1_val, resp0_val}, {prev, ~prev}); end
            end
            prev = g_exp;
            tick();
        end
        req0_val = 0; req1_val = 0;
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_drain_idle got %0b exp 1", idle); end
    endtask

    task automatic test_full();
        do_reset();
        req0_val = 1; req0_msg = mk_req(8'h30, 32'h0000_3000);
        mem_req_rdy = 1; resp0_rdy = 1;
        repeat (2) tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({mem_req_val, req0_rdy, req1_rdy} !== 3'b000) begin errors++; $display("FAIL full_block cyc %0d got %b exp 000", i, {mem_req_val, req0_rdy, req1_rdy}); end
            tick();
        end
        mem_resp_val = 1;
        #1;
        checks++; if (mem_resp_rdy !== 1'b1 || mem_req_val !== 1'b0) begin errors++; $display("FAIL full_no_bypass got resp_rdy/req_val %0b/%0b exp 1/0", mem_resp_rdy, mem_req_val); end
        tick();
        mem_resp_val = 0;
        #1;
        checks++; if ({mem_req_val, req0_rdy} !== 2'b11) begin errors++; $display("FAIL full_release got %b exp 11", {mem_req_val, req0_rdy}); end
    endtask

    task automatic test_in_order();
        do_reset();
        mem_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        req1_val = 1; req1_msg = mk_req(8'h41, 32'h0000_4100);
        tick();
        req1_val = 0; req0_val = 1; req0_msg = mk_req(8'h40, 32'h0000_4000);
        tick();
        req0_val = 0;
        mem_resp_val = 1; mem_resp_msg = mk_resp(8'h41, 32'h0000_AAAA);
        #1;
        checks++; if ({resp1_val, resp0_val} !== 2'b10 || resp1_msg.data !== 32'h0000_AAAA) begin errors++; $display("FAIL order_first got v=%b d=%h exp v=10 d=0000aaaa", {resp1_val, resp0_val}, resp1_msg.data); end
        tick();
        mem_resp_msg = mk_resp(8'h40, 32'h0000_BBBB);
        #1;
        checks++; if ({resp1_val, resp0_val} !== 2'b01 || resp0_msg !== mem_resp_msg) begin errors++; $display("FAIL order_second got v=%b d=%h exp v=01 d=0000bbbb", {resp1_val, resp0_val}, resp0_msg.data); end
        tick();
        #1;
        checks++; if ({resp1_val, resp0_val, mem_resp_rdy, idle} !== 4'b0001) begin errors++; $display("FAIL orphan_resp got %b exp 0001", {resp1_val, resp0_val, mem_resp_rdy, idle}); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL orphan_idle got %0b exp 1", idle); end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_req_rdy = 1;
        req0_val = 1; req0_msg = mk_req(8'h50, 32'h0000_5000);
        tick();
        req0_val = 0; req1_val = 1; req1_msg = mk_req(8'h51, 32'h0000_5100);
        tick();
        req1_val = 0;
        mem_resp_val = 1; resp0_rdy = 0; resp1_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b100) begin errors++; $display("FAIL bp_hold cyc %0d got %b exp 100", i, {resp0_val, resp1_val, mem_resp_rdy}); end
            tick();
        end
        resp0_rdy = 1;
        #1;
        checks++; if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", mem_resp_rdy); end
        tick();
        resp0_rdy = 0;
        #1;
        checks++; if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b011) begin errors++; $display("FAIL bp_next_owner got %b exp 011", {resp0_val, resp1_val, mem_resp_rdy}); end
    endtask

    task automatic test_back_to_back();
        logic q[$];
        logic p, h;
        do_reset();
        mem_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        req0_val = 1; req0_msg = mk_req(8'h60, 32'h0000_6000);
        q.push_back(1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            p = (i % 3 == 0) ? 1'b0 : 1'b1;
            req0_val = ~p; req1_val = p;
            req0_msg = mk_req(8'(8'h70 + i), 32'h0000_7000);
            req1_msg = mk_req(8'(8'h80 + i), 32'h0000_8000);
            mem_resp_val = 1; mem_resp_msg = mk_resp(8'(i), 32'(32'h0000_D000 + i));
            h = q.pop_front();
            q.push_back(p);
            #1;
            checks++; if ({resp1_val, resp0_val, mem_resp_rdy, mem_req_val} !== {h, ~h, 2'b11}) begin errors++; $display("FAIL b2b cyc %0d got %b exp %b", i, {resp1_val, resp0_val, mem_resp_rdy, mem_req_val}, {h, ~h, 2'b11}); end
            tick();
            checks++; if (idle !== 1'b0) begin errors++; $display("FAIL b2b_count cyc %0d idle got %0b exp 0", i, idle); end
        end
        req0_val = 0; req1_val = 0;
        h = q.pop_front();
        #1;
        checks++; if ({resp1_val, resp0_val} !== {h, ~h}) begin errors++; $display("FAIL b2b_tail got %b exp %b", {resp1_val, resp0_val}, {h, ~h}); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got %0b exp 1", idle); end
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_round_robin();
        test_full();
        test_in_order();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab3_cache_mem_arbiter.md
LAB3_CACHE_MEM_ARBITER -- requirements
Module: lab3_cache_MemArbiter

Interface
REQ-001 The block SHALL have parameter p_depth, default 2, giving the maximum number of outstanding memory requests tracked (integer, 1..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_val input 1, req0_rdy output 1, and req0_msg input mem_req_4B_t (77), carrying the port-0 (icache) request.
REQ-005 The block SHALL have ports resp0_val output 1, resp0_rdy input 1, and resp0_msg output mem_resp_4B_t (47), carrying the port-0 response.
REQ-006 The block SHALL have ports req1_val, req1_rdy, req1_msg, resp1_val, resp1_rdy, and resp1_msg, identical to port 0, carrying the port-1 (dcache) traffic.
REQ-007 The block SHALL have ports mem_req_val output 1, mem_req_rdy input 1, and mem_req_msg output mem_req_4B_t (77), carrying the shared memory request.
REQ-008 The block SHALL have ports mem_resp_val input 1, mem_resp_rdy output 1, and mem_resp_msg input mem_resp_4B_t (47), carrying the shared memory response.
REQ-009 The block SHALL have port idle, output 1, asserted high when no request is outstanding.

Function
REQ-010 The block SHALL be a val/rdy arbiter that shares one memory port between two cache refill ports, with in-order response routing.
REQ-011 The request path SHALL be combinational (zero latency): mem_req_val = (req0_val | req1_val) & !full.
REQ-012 grant SHALL select port 0 or port 1, and mem_req_msg SHALL equal the granted reqN_msg, unmodified (opaque field untouched).
REQ-013 Each reqN_rdy SHALL equal (grant==N) & mem_req_rdy & !full; the non-granted port SHALL see rdy=0.
REQ-014 Grant policy SHALL be round-robin using a 1-bit priority register: if both ports are valid, the favoured port wins; if only one is valid, that port wins.
REQ-015 On each request fire (mem_req_val & mem_req_rdy), the priority register SHALL favour the port that was not granted; it SHALL not change in cycles without a fire.
REQ-016 On each request fire, the granted port id SHALL be pushed into an owner FIFO of p_depth entries.
REQ-017 full SHALL be count==p_depth; when full, no push SHALL occur even if a pop occurs in the same cycle (no bypass).
REQ-018 Responses SHALL be routed to the owner at the FIFO head: respH_val = mem_resp_val & !empty; the other respN_val SHALL be 0.
REQ-019 mem_resp_rdy SHALL equal respH_rdy & !empty.
REQ-020 respN_msg SHALL equal mem_resp_msg for both ports, unmodified.
REQ-021 Each response fire SHALL pop the FIFO head.
REQ-022 The block SHALL support a push and a pop in the same cycle (when not full) with count unchanged and correct head/tail wrap-around modulo p_depth.
REQ-023 mem_resp_val while empty SHALL be ignored: mem_resp_rdy=0, no routing, and no state change.
REQ-024 idle SHALL equal (count==0).
REQ-025 The block SHALL sustain one request per cycle and one response per cycle, with no combinational loop from rdy back to val.

Reset
REQ-026 While reset is low, the block SHALL asynchronously clear count, head, and tail pointers, and set the priority register to favour port 0.
REQ-027 During reset, the block SHALL drive mem_req_val=0, req0_rdy=req1_rdy=0, resp0_val=resp1_val=0, mem_resp_rdy=0, and idle=1.
REQ-028 On reset asserted mid-operation, all outstanding ownership SHALL be discarded; the memory side must be reset concurrently, and later orphan responses are handled per REQ-023.
REQ-029 Reset deassertion SHALL be synchronized externally; the first grant SHALL occur at the first rising edge after deassertion.

Configuration
REQ-030 The macro LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN SHALL select the grant policy.
REQ-031 With LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN defined, the block SHALL use fixed priority, with port 1 (dcache) always winning over port 0; the priority register is removed and REQ-015 does not apply.
REQ-032 Without LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN, the block SHALL use round-robin per REQ-014 and REQ-015.
REQ-033 All other behaviour SHALL be identical with or without the macro.

Verification
REQ-034 The bench SHALL cover: reset low for 3 cycles then high, with req0 holding a read to addr 0x1000 and mem_req_rdy=1 -> the request fires on the first edge after reset, mem_req_msg.addr=0x1000, and idle goes 0.
REQ-035 The bench SHALL cover: both ports valid each cycle with mem always ready (round-robin build) -> grants alternate 0,1,0,1; with the macro defined, port 1 wins every cycle.
REQ-036 The bench SHALL cover: p_depth=2, two requests fired with resp held off -> third request sees req*_rdy=0 and mem_req_val=0 until the first response fires.
REQ-037 The bench SHALL cover: requests fired in order port1 then port0, responses with data 0xAAAA then 0xBBBB -> resp1 receives 0xAAAA and resp0 receives 0xBBBB, in that order.
REQ-038 The bench SHALL cover: resp0_rdy=0 while the head owner is 0 -> mem_resp_rdy=0 and resp1_val=0 until resp0_rdy=1.
REQ-039 The bench SHALL cover: push and pop in the same cycle at count=1 for 10 cycles -> count stays 1, pointers wrap, and routing stays correct.
